// File: rtl/adam_periph_spi_fifo_pkg.sv
// -----------------------------------------------------------------------------
// adam_periph_spi_fifo_pkg
//
// Purpose:
//   Shared constants for the SPI peripheral stream FIFOs. This package holds:
//   - the bit positions of the FIFO status flags in the SPI status register;
//   - a helper that sizes the level counter.
//   Stream word types are deliberately not defined here. Each FIFO instance
//   derives its word type locally from its own DATA_WIDTH.
//
// Ports: none (package).
// -----------------------------------------------------------------------------
package adam_periph_spi_fifo_pkg;

    // Status-register bit positions for one FIFO's flags.
    // The TX and RX FIFOs are placed at different base offsets in the register.
    localparam int unsigned SPI_FIFO_STAT_EMPTY_BIT = 0;
    localparam int unsigned SPI_FIFO_STAT_FULL_BIT  = 1;
    localparam int unsigned SPI_FIFO_STAT_THR_BIT   = 2;
    localparam int unsigned SPI_FIFO_STAT_WIDTH     = 3;

    // Register-map offsets of each FIFO's status field.
    localparam int unsigned SPI_FIFO_STAT_TX_BASE = 0;
    localparam int unsigned SPI_FIFO_STAT_RX_BASE = SPI_FIFO_STAT_WIDTH;

    // The level must represent 0..DEPTH inclusive.
    // That range needs one bit more than the pointer width.
    function automatic int unsigned fifo_level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : adam_periph_spi_fifo_pkg

// File: rtl/adam_periph_spi_fifo_mem.sv
// -----------------------------------------------------------------------------
// adam_periph_spi_fifo_mem
//
// Purpose:
//   DEPTH x DATA_WIDTH storage array for the SPI stream FIFO.
//   - One synchronous write port.
//   - One asynchronous (combinational) read port.
//   Because the read port is asynchronous, a word written at edge N is
//   visible at the read port during cycle N+1.
//
// Ports:
//   clk      in   sole clock; the write port updates on its rising edge
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  array contents at rd_addr (combinational)
// -----------------------------------------------------------------------------
module adam_periph_spi_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the storage array has no reset.
    // Every entry is written before it can be read, because the level gates o_valid.
    // Clearing it would only add a wide reset fan-out for no functional benefit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule : adam_periph_spi_fifo_mem

// File: rtl/adam_periph_spi_fifo.sv
// -----------------------------------------------------------------------------
// adam_periph_spi_fifo
//
// Purpose:
//   Valid/ready stream FIFO used twice inside the SPI peripheral:
//   - TX path: register file -> SPI PHY tx stream.
//   - RX path: SPI PHY rx stream -> register file.
//   Words leave in the order they were accepted.
//   A pause handshake freezes both stream sides while keeping the stored contents.
//   Flush discards all stored entries.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset; wins over everything else
//   pause_req  in   pause request
//   pause_ack  out  registered pause state (0 = RUN, 1 = PAUSED)
//   flush      in   drop all entries; concurrent transfers are discarded
//   threshold  in   level at which thr_flag asserts
//   i_data     in   upstream stream word
//   i_valid    in   upstream valid
//   i_ready    out  upstream ready
//   o_data     out  downstream stream word (head entry)
//   o_valid    out  downstream valid
//   o_ready    in   downstream ready
//   level      out  number of stored entries, 0..DEPTH
//   empty      out  level == 0
//   full       out  level == DEPTH
//   thr_flag   out  level >= threshold
//
// DEPTH must be a power of two and at least 2.
// This lets the pointers wrap modulo DEPTH with plain binary overflow.
// -----------------------------------------------------------------------------
module adam_periph_spi_fifo
    import adam_periph_spi_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned LEVEL_WIDTH = fifo_level_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   pause_req,
    output logic                   pause_ack,

    input  logic                   flush,
    input  logic [LEVEL_WIDTH-1:0] threshold,

    input  logic [DATA_WIDTH-1:0]  i_data,
    input  logic                   i_valid,
    output logic                   i_ready,

    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_valid,
    input  logic                   o_ready,

    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   empty,
    output logic                   full,
    output logic                   thr_flag
);

    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

    typedef logic [DATA_WIDTH-1:0] word_t;

    typedef enum logic {
        PAUSE_RUN    = 1'b0,
        PAUSE_PAUSED = 1'b1
    } pause_state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    pause_state_e           state_q,  state_d;
    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LEVEL_WIDTH-1:0] level_q,  level_d;

    logic  paused;
    logic  wr_en;
    logic  rd_en;
    word_t head_data;

    // -------------------------------------------------------------------------
    // Pause FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before any branch.
    // A path that leaves a variable unassigned would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PAUSE_RUN:    if (pause_req)  state_d = PAUSE_PAUSED;
            PAUSE_PAUSED: if (!pause_req) state_d = PAUSE_RUN;
            default:      state_d = PAUSE_PAUSED;
        endcase
    end

    assign pause_ack = (state_q == PAUSE_PAUSED);

    // A rising request blocks handshakes in the same cycle, before the state
    // register catches up. A falling request keeps them blocked until ack drops.
    assign paused = pause_req || pause_ack;

    // -------------------------------------------------------------------------
    // Status and handshakes
    // -------------------------------------------------------------------------
    assign empty    = (level_q == '0);
    assign full     = (level_q == LEVEL_WIDTH'(DEPTH));
    assign thr_flag = (level_q >= threshold);
    assign level    = level_q;

    assign i_ready = !full && !paused && !flush;
    assign o_valid = !empty && !paused;
    assign o_data  = head_data;

    assign wr_en = i_valid && i_ready;

    // A read that coincides with a flush is discarded along with everything else.
    assign rd_en = o_valid && o_ready && !flush;

    // -------------------------------------------------------------------------
    // Pointer and level next-state
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);

            // A simultaneous read and write leaves the level unchanged.
            unique case ({wr_en, rd_en})
                2'b10:   level_d = level_q + LEVEL_WIDTH'(1);
                2'b01:   level_d = level_q - LEVEL_WIDTH'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only.
    // All flops then sample their _d values from before the edge, independent of process order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset parks the FIFO in PAUSED.
            // The owner must drop pause_req before any traffic flows.
            state_q  <= PAUSE_PAUSED;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    adam_periph_spi_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (i_data),
        .rd_addr (rd_ptr_q),
        .rd_data (head_data)
    );

endmodule : adam_periph_spi_fifo

// File: tb/tb_adam_periph_spi_fifo.sv
// -----------------------------------------------------------------------------
// tb_adam_periph_spi_fifo
//
// Self-checking bench for adam_periph_spi_fifo (DATA_WIDTH=32, DEPTH=8).
//
// Scoreboard:
//   - Every accepted input word is pushed onto a queue.
//   - Every emitted output word is popped from the queue and compared.
//   - Flush and reset empty the queue.
//
// Timing:
//   - Stimulus changes 1 time unit after the rising edge.
//   - The handshake monitor samples on the falling edge.
// -----------------------------------------------------------------------------
module tb_adam_periph_spi_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          pause_req;
    logic          pause_ack;
    logic          flush;
    logic [LW-1:0] threshold;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_ready;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          thr_flag;

    int            n_checks = 0;
    int            n_errors = 0;
    int            n_popped = 0;
    logic [DW-1:0] sb [$];

    always #5 clk = ~clk;

    adam_periph_spi_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pause_req (pause_req),
        .pause_ack (pause_ack),
        .flush     (flush),
        .threshold (threshold),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .level     (level),
        .empty     (empty),
        .full      (full),
        .thr_flag  (thr_flag)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: handshakes sampled here complete at the next rising edge.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (o_valid && o_ready) begin
                if (sb.size() == 0) begin
                    check("out_with_empty_sb", {31'd0, o_valid}, 32'd0);
                end else begin
                    check("out_data", o_data, sb.pop_front());
                    n_popped++;
                end
            end
            if (i_valid && i_ready) sb.push_back(i_data);
        end
    end

    task automatic write_words(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            int waited;
            bit took;
            waited  = 0;
            took    = 1'b0;
            i_valid = 1'b1;
            i_data  = base + k;
            while (!took && waited < 50) begin
                took = i_ready;
                tick();
                waited++;
            end
            if (!took) check("write_timeout", {31'd0, took}, 32'd1);
        end
        i_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int c;
        c       = 0;
        o_ready = 1'b1;
        while (!empty && c < max_cycles) begin
            tick();
            c++;
        end
        o_ready = 1'b0;
        check("drain_empty", {31'd0, empty}, 32'd1);
        check("drain_sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        pause_req = 1'b0;
        flush     = 1'b0;
        threshold = 4'd4;
        i_data    = '0;
        i_valid   = 1'b0;
        o_ready   = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_level",   {28'd0, level},     32'd0);
        check("rst_empty",   {31'd0, empty},     32'd1);
        check("rst_full",    {31'd0, full},      32'd0);
        check("rst_ack",     {31'd0, pause_ack}, 32'd1);
        check("rst_i_ready", {31'd0, i_ready},   32'd0);
        check("rst_o_valid", {31'd0, o_valid},   32'd0);
        rst = 1'b0;
        tick();
        check("run_ack",     {31'd0, pause_ack}, 32'd0);
        check("run_i_ready", {31'd0, i_ready},   32'd1);

        // ---------------- fill / drain ----------------
        write_words(32'h1, 8);
        check("fill_full",    {31'd0, full},    32'd1);
        check("fill_level",   {28'd0, level},   32'd8);
        check("fill_i_ready", {31'd0, i_ready}, 32'd0);
        check("fill_thr",     {31'd0, thr_flag}, 32'd1);
        i_valid = 1'b1;
        i_data  = 32'h99;
        tick();
        i_valid = 1'b0;
        check("full_no_write_level", {28'd0, level}, 32'd8);
        n_popped = 0;
        drain(20);
        check("fill_popped", n_popped, 32'd8);

        // ---------------- simultaneous read/write across pointer wrap ----------------
        write_words(32'h100, 3);
        check("sim_level_start", {28'd0, level}, 32'd3);
        i_valid = 1'b1;
        o_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            i_data = 32'h200 + k;
            tick();
            check("sim_level_hold", {28'd0, level}, 32'd3);
        end
        i_valid  = 1'b0;
        n_popped = 0;
        drain(20);
        check("sim_popped_tail", n_popped, 32'd3);

        // ---------------- write-to-read latency ----------------
        i_valid = 1'b1;
        i_data  = 32'hA5;
        check("lat_o_valid_before", {31'd0, o_valid}, 32'd0);
        tick();
        i_valid = 1'b0;
        check("lat_o_valid_after", {31'd0, o_valid}, 32'd1);
        check("lat_o_data_after",  o_data, 32'hA5);
        drain(10);

        // ---------------- threshold boundaries ----------------
        threshold = 4'd0;
        #1;
        check("thr_zero_empty", {31'd0, thr_flag}, 32'd1);
        threshold = 4'd2;
        write_words(32'h50, 1);
        check("thr_below", {31'd0, thr_flag}, 32'd0);
        write_words(32'h51, 1);
        check("thr_equal", {31'd0, thr_flag}, 32'd1);
        drain(10);
        threshold = 4'd4;

        // ---------------- pause ----------------
        write_words(32'h300, 5);
        check("pause_level_start", {28'd0, level}, 32'd5);
        pause_req = 1'b1;
        i_valid   = 1'b1;
        i_data    = 32'hBAD;
        o_ready   = 1'b1;
        #1;
        check("pause_i_ready_same", {31'd0, i_ready},   32'd0);
        check("pause_o_valid_same", {31'd0, o_valid},   32'd0);
        check("pause_ack_same",     {31'd0, pause_ack}, 32'd0);
        tick();
        check("pause_ack_next",   {31'd0, pause_ack}, 32'd1);
        check("pause_level_hold", {28'd0, level},     32'd5);
        tick();
        check("pause_level_hold2", {28'd0, level}, 32'd5);
        pause_req = 1'b0;
        i_valid   = 1'b0;
        #1;
        check("unpause_o_valid_same", {31'd0, o_valid}, 32'd0);
        tick();
        check("unpause_ack",   {31'd0, pause_ack}, 32'd0);
        check("unpause_level", {28'd0, level},     32'd5);
        check("unpause_head",  o_data,             32'h300);
        n_popped = 0;
        drain(20);
        check("pause_popped", n_popped, 32'd5);

        // ---------------- flush collision ----------------
        write_words(32'h400, 4);
        check("flush_level_start", {28'd0, level}, 32'd4);
        flush   = 1'b1;
        i_valid = 1'b1;
        i_data  = 32'hF00D;
        tick();
        flush   = 1'b0;
        i_valid = 1'b0;
        check("flush_level", {28'd0, level}, 32'd0);
        check("flush_empty", {31'd0, empty}, 32'd1);
        tick();
        check("flush_no_word", {31'd0, o_valid}, 32'd0);

        // ---------------- flush while paused ----------------
        write_words(32'h450, 2);
        pause_req = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_paused_level", {28'd0, level}, 32'd0);
        pause_req = 1'b0;
        tick();
        check("flush_paused_resume", {31'd0, pause_ack}, 32'd0);

        // ---------------- reset mid-operation ----------------
        threshold = 4'd4;
        write_words(32'h500, 6);
        check("rstmid_level_pre", {28'd0, level},    32'd6);
        check("rstmid_thr_pre",   {31'd0, thr_flag}, 32'd1);
        rst     = 1'b1;
        i_valid = 1'b1;
        i_data  = 32'h5A5A;
        tick();
        rst     = 1'b0;
        i_valid = 1'b0;
        check("rstmid_level", {28'd0, level},     32'd0);
        check("rstmid_thr",   {31'd0, thr_flag},  32'd0);
        check("rstmid_ack",   {31'd0, pause_ack}, 32'd1);
        check("rstmid_empty", {31'd0, empty},     32'd1);
        tick();
        check("rstmid_run", {31'd0, pause_ack}, 32'd0);

        // Normal traffic after reset.
        write_words(32'h600, 2);
        n_popped = 0;
        drain(10);
        check("post_rst_popped", n_popped, 32'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_adam_periph_spi_fifo

// File: doc/adam_periph_spi_fifo.md
ADAM_PERIPH_SPI_FIFO -- requirements
Module: adam_periph_spi_fifo

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 32, stream word width (matches SPI PHY data width).
REQ-002 SHALL take parameter DEPTH, default 8, entries; power of two, minimum 2.
REQ-003 SHALL derive parameter LEVEL_WIDTH, default $clog2(DEPTH)+1, width of the level count; not overridden.
REQ-004 SHALL use a single clock and a synchronous, active-high reset: seq.clk, input, 1, sole clock, all state changes on its rising edge.
REQ-005 SHALL have seq.rst, input, 1, synchronous active-high reset (ADAM_SEQ.Slave).
REQ-006 SHALL have pause.req, input, 1, pause request (ADAM_PAUSE.Slave).
REQ-007 SHALL have pause.ack, output, 1, pause acknowledge.
REQ-008 SHALL have flush, input, 1, discard all stored entries.
REQ-009 SHALL have threshold, input, LEVEL_WIDTH, level at which thr_flag asserts.
REQ-010 SHALL have i.data/i.valid/i.ready, slave stream, DATA_WIDTH/1/1, upstream side (register file for TX, SPI PHY rx for RX).
REQ-011 SHALL have o.data/o.valid/o.ready, master stream, DATA_WIDTH/1/1, downstream side (SPI PHY tx for TX, register file for RX).
REQ-012 SHALL have level, output, LEVEL_WIDTH, current entry count 0..DEPTH.
REQ-013 SHALL have empty, full, thr_flag, outputs, 1 each, status flags for interrupt logic.

Function
REQ-014 SHALL store words in order of acceptance and emit them in the same order; no loss, duplication or reorder.
REQ-015 SHALL accept a word when i.valid && i.ready on a rising edge; SHALL emit a word when o.valid && o.ready.
REQ-016 SHALL drive i.ready = !full && !paused && !flush, combinationally; no write bypass at full.
REQ-017 SHALL drive o.valid = !empty && !paused, o.data = head entry, combinationally from storage.
REQ-018 SHALL have write-to-read latency of 1 cycle: word written at edge N visible on o at cycle N+1 from empty.
REQ-019 SHALL, on simultaneous read and write (not empty, not full), keep level unchanged and advance both pointers.
REQ-020 SHALL wrap read and write pointers modulo DEPTH; level = write count minus read count, never exceeding DEPTH.
REQ-021 SHALL assert empty when level == 0, full when level == DEPTH, thr_flag when level >= threshold (threshold 0 gives thr_flag=1 always).
REQ-022 SHALL, on flush high at an edge, set both pointers and level to 0 on that edge; any concurrent write or read is discarded; storage contents need not be cleared.
REQ-023 SHALL implement pause FSM with states RUN and PAUSED; pause.ack is the registered state (0=RUN, 1=PAUSED).
REQ-024 SHALL transition RUN->PAUSED on the first edge with pause.req=1; "paused" in REQ-016/017 is pause.req || pause.ack, so no handshake completes in the cycle req rises.
REQ-025 SHALL transition PAUSED->RUN on the first edge with pause.req=0; streams resume the following cycle.
REQ-026 SHALL preserve stored contents and level across pause; flush SHALL be honoured while paused.

Reset
REQ-027 SHALL, on seq.rst at an edge, set pointers and level to 0, pause.ack=1 (PAUSED), giving i.ready=0, o.valid=0, empty=1, full=0.
REQ-028 SHALL let seq.rst take priority over flush, pause and stream transfers; reset mid-transfer discards all contents.

Structure
REQ-029 SHALL place no new typedefs in a shared package; the stream width type follows DATA_WIDTH locally, and status-flag bit positions for the SPI register map go in the existing SPI peripheral package.
REQ-030 SHALL instantiate one storage sub-module, adam_periph_spi_fifo_mem (DEPTH x DATA_WIDTH, one synchronous write port, one asynchronous read port).
REQ-031 SHALL be instantiated twice in the SPI peripheral: TX path feeding the PHY tx stream, RX path consuming the PHY rx stream.

Verification
REQ-032 SHALL test fill/drain: DEPTH=8, write 0x1..0x8 with o.ready=0 -> full=1, level=8, i.ready=0; then o.ready=1 -> 0x1..0x8 out in order, empty=1.
REQ-033 SHALL test simultaneous: level=3, i.valid=o.ready=1 for 20 cycles with counting data -> level stays 3, order preserved across pointer wrap.
REQ-034 SHALL test latency: empty FIFO, write 0xA5 at edge N -> o.valid=1, o.data=0xA5 at cycle N+1, not N.
REQ-035 SHALL test pause: level=5, raise pause.req -> i.ready=o.valid=0 same cycle, pause.ack=1 next edge; drop req -> ack=0 next edge, same 5 words out intact.
REQ-036 SHALL test flush collision: level=4, flush=1 with i.valid=1 -> level=0, empty=1 next cycle, written word absent.
REQ-037 SHALL test reset mid-operation: level=6, threshold=4 (thr_flag=1), assert seq.rst -> level=0, thr_flag=0, pause.ack=1.
